z80_bus_responder: RTL and testbench

- Bus target for the tv80s core. Answers memory and I/O cycles the CPU initiates on its Z80-style strobe bus.
- Translates each CPU read or write into one request on a synchronous backing-store port that may complete with arbitrary latency.
- Holds the CPU with wait_n until data is available, then drives di.
- Replaces the behavioural memory model in CPU-level benches and feeds the block-RAM/SDRAM adapters in the SoC.

---
 rtl/z80_bus_pkg.sv | 63 ++++++
 rtl/z80_bus_decode.sv | 34 +++
 rtl/z80_bus_responder.sv | 142 ++++++++++++++
 tb/tb_z80_bus_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg
//   Shared types and helpers for the Z80-style strobe bus responder.
//   access_t      : bus cycle class decoded from the CPU strobes
//   state_t       : responder FSM states
//   decode_access : strobe decoder (pure combinational function)
//   access_is_io  : true for I/O-space accesses (IORD/IOWR)
//   access_is_wr  : true for write accesses (MWR/IOWR)
package z80_bus_pkg;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_MRD,
        ACC_MWR,
        ACC_IORD,
        ACC_IOWR,
        ACC_INTA
    } access_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_STALL,
        ST_HOLD
    } state_t;

    // Interrupt acknowledge is checked first because it shares iorq_n with
    // the I/O classes. Refresh is rejected before the memory classes so a
    // refresh cycle can never look like a memory access.
    function automatic access_t decode_access(
        input logic m1_n,
        input logic mreq_n,
        input logic iorq_n,
        input logic rd_n,
        input logic wr_n,
        input logic rfsh_n
    );
        access_t acc;
        acc = ACC_NONE;
        if (!iorq_n && !m1_n) begin
            acc = ACC_INTA;
        end else if (!iorq_n && !rd_n) begin
            acc = ACC_IORD;
        end else if (!iorq_n && !wr_n) begin
            acc = ACC_IOWR;
        end else if (!mreq_n && !rfsh_n) begin
            acc = ACC_NONE;
        end else if (!mreq_n && !rd_n) begin
            acc = ACC_MRD;
        end else if (!mreq_n && !wr_n) begin
            acc = ACC_MWR;
        end
        return acc;
    endfunction

    function automatic logic access_is_io(input access_t acc);
        return (acc == ACC_IORD) || (acc == ACC_IOWR);
    endfunction

    function automatic logic access_is_wr(input access_t acc);
        return (acc == ACC_MWR) || (acc == ACC_IOWR);
    endfunction

endpackage

// File: rtl/z80_bus_decode.sv
// z80_bus_decode
//   Combinational strobe decoder and store-address mapping.
//   Ports:
//     A           in  16  CPU address
//     m1_n..rfsh_n in  1  CPU strobes (active low)
//     acc         out     decoded access class
//     store_addr  out 16  backing-store address for this access
//     is_write    out  1  access is a write (MWR or IOWR)
module z80_bus_decode
    import z80_bus_pkg::*;
#(
    parameter logic [7:0] IO_PAGE = 8'h10
) (
    input  logic [15:0] A,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output access_t     acc,
    output logic [15:0] store_addr,
    output logic        is_write
);

    always_comb begin
        acc        = decode_access(m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n);
        is_write   = access_is_wr(acc);
        // I/O port n lives in one 256-byte page of the store; the CPU's
        // upper address byte (accumulator/B during I/O) is discarded.
        store_addr = access_is_io(acc) ? {IO_PAGE, A[7:0]} : A;
    end

endmodule

// File: rtl/z80_bus_responder.sv
// z80_bus_responder
//   Bus target for the tv80s core. Each CPU memory/I/O cycle becomes one
//   request on a synchronous backing-store port of arbitrary latency; the
//   CPU is held with wait_n until read data is on di.
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     A, dout               CPU address and write data
//     m1_n..rfsh_n          CPU strobes
//     di                    read data / interrupt vector to the CPU
//     wait_n                CPU wait request (combinational)
//     mem_req/we/addr/wdata backing-store request, held until mem_ack
//     mem_rdata, mem_ack    store read data and completion pulse
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES   = 0,
    parameter logic [7:0]  IO_PAGE       = 8'h10,
    parameter logic [7:0]  INTACK_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output logic [7:0]  di,
    output logic        wait_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    access_t     acc;
    logic [15:0] store_addr;
    logic        is_write;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        rd_pending;
    logic        aborted;
    logic        released;

    z80_bus_decode #(
        .IO_PAGE (IO_PAGE)
    ) u_decode (
        .A          (A),
        .m1_n       (m1_n),
        .mreq_n     (mreq_n),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .rfsh_n     (rfsh_n),
        .acc        (acc),
        .store_addr (store_addr),
        .is_write   (is_write)
    );

    assign released = mreq_n && iorq_n;

    // wait_n drops in the same cycle the strobe is decoded so the CPU sees
    // it in the following T-state, before the FSM has even left IDLE.
    always_comb begin
        wait_n = 1'b1;
        case (state)
            ST_IDLE:  if (acc != ACC_NONE && acc != ACC_INTA) wait_n = 1'b0;
            ST_REQ:   wait_n = 1'b0;
            ST_STALL: wait_n = 1'b0;
            default:  wait_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            rd_pending <= 1'b0;
            aborted    <= 1'b0;
            di         <= 8'hFF;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc == ACC_INTA) begin
                        di    <= INTACK_VECTOR;
                        state <= ST_HOLD;
                    end else if (acc != ACC_NONE) begin
                        mem_req    <= 1'b1;
                        mem_we     <= is_write;
                        mem_addr   <= store_addr;
                        if (is_write) mem_wdata <= dout;
                        rd_pending <= !is_write;
                        aborted    <= 1'b0;
                        state      <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if (rd_pending) di <= mem_rdata;
                        wait_cnt <= WS;
                        // A CPU that dropped its strobes mid-request has no
                        // cycle left to hold, so skip straight back to IDLE.
                        if (aborted || released) begin
                            state <= ST_IDLE;
                        end else if (WS != 4'd0) begin
                            state <= ST_STALL;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end else if (released) begin
                        aborted <= 1'b1;
                    end
                end

                ST_STALL: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) state <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (released) state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder
//   Randomized bench for z80_bus_responder. A CPU-side driver produces
//   strobe cycles, a backing-store process answers requests with random
//   latency, and an address-level model predicts requests, wait length
//   and di for every cycle.
module tb_z80_bus_responder;

    localparam int unsigned WS   = 2;
    localparam logic [7:0]  PAGE = 8'h10;

    localparam int K_MRD  = 0;
    localparam int K_MWR  = 1;
    localparam int K_IORD = 2;
    localparam int K_IOWR = 3;
    localparam int K_INTA = 4;
    localparam int K_RFSH = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] A;
    logic [7:0]  dout;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [7:0]  di;
    logic        wait_n;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    z80_bus_responder #(
        .WAIT_STATES   (WS),
        .IO_PAGE       (PAGE),
        .INTACK_VECTOR (8'hFF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .A         (A),
        .dout      (dout),
        .m1_n      (m1_n),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .rfsh_n    (rfsh_n),
        .di        (di),
        .wait_n    (wait_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Initial store contents, shared by the store and the model.
    function automatic logic [7:0] init_byte(input int i);
        logic [15:0] a;
        a = 16'(i);
        case (a)
            16'h0000: return 8'hCB;
            16'h0001: return 8'hD6;
            16'h6029: return 8'hB7;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5C;
        endcase
    endfunction

    // ---------------- backing store ----------------
    logic [7:0]  store [0:65535];
    int          lat_fixed = 0;
    bit          responder_en = 1'b1;
    int          late_tok = 0;
    int          late_seen = 0;
    int          req_count = 0;
    int          last_lat = 0;
    logic [15:0] last_addr;
    logic        last_we;
    logic [7:0]  last_wdata;

    initial begin
        int lat;
        for (int i = 0; i < 65536; i++) store[i] = init_byte(i);
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (late_tok != late_seen) begin
                late_seen++;
                mem_ack = 1'b1;
            end else if (responder_en && reset_n && mem_req) begin
                lat        = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
                last_lat   = lat;
                req_count++;
                last_addr  = mem_addr;
                last_we    = mem_we;
                last_wdata = mem_wdata;
                repeat (lat - 1) begin @(posedge clk); #1; end
                check("req_stable", {mem_req, mem_we, mem_addr, mem_wdata},
                      {1'b1, last_we, last_addr, last_wdata});
                if (mem_we) store[mem_addr] = mem_wdata;
                else        mem_rdata = store[mem_addr];
                mem_ack = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] model_mem [0:65535];
    logic [7:0] exp_di = 8'hFF;

    task automatic release_strobes();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    // One CPU bus cycle: assert strobes, wait for wait_n, hold, release.
    task automatic cpu_cycle(input int kind, input logic [15:0] addr,
                             input logic [7:0] data, input int hold_extra, input bit m1);
        int          base, lowc, holdlow;
        bit          done, is_req, is_wr, is_rd;
        logic [15:0] ea;
        @(posedge clk); #1;
        base = req_count;
        A    = addr;
        dout = data;
        case (kind)
            K_MRD:  begin mreq_n = 1'b0; rd_n = 1'b0; m1_n = ~m1; end
            K_MWR:  begin mreq_n = 1'b0; wr_n = 1'b0; end
            K_IORD: begin iorq_n = 1'b0; rd_n = 1'b0; end
            K_IOWR: begin iorq_n = 1'b0; wr_n = 1'b0; end
            K_INTA: begin iorq_n = 1'b0; m1_n = 1'b0; end
            default: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
        endcase
        lowc = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (wait_n) done = 1'b1;
            else        lowc++;
        end
        check("wait_timeout", 32'(done), 32'd1);
        holdlow = 0;
        repeat (hold_extra) begin
            @(negedge clk);
            if (!wait_n) holdlow++;
        end
        check("hold_wait_low", holdlow, 0);
        @(posedge clk); #1;
        release_strobes();

        is_req = (kind <= K_IOWR);
        is_wr  = (kind == K_MWR) || (kind == K_IOWR);
        is_rd  = (kind == K_MRD) || (kind == K_IORD);
        ea     = (kind == K_IORD || kind == K_IOWR) ? {PAGE, addr[7:0]} : addr;

        check("req_count", req_count - base, is_req ? 1 : 0);
        check("wait_cycles", lowc, is_req ? 1 + last_lat + int'(WS) : 0);
        if (is_req) begin
            check("req_addr", last_addr, ea);
            check("req_we", 32'(last_we), 32'(is_wr));
            if (is_wr) check("req_wdata", last_wdata, data);
        end
        if (is_wr)          model_mem[ea] = data;
        if (is_rd)          exp_di = model_mem[ea];
        if (kind == K_INTA) exp_di = 8'hFF;
        check("di", di, exp_di);
    endtask

    // SET 2,(HL) with HL=6029 as seen on the bus, with refresh after M1s.
    task automatic run_program();
        cpu_cycle(K_MRD,  16'h0000, 8'h00, 1, 1'b1);
        cpu_cycle(K_RFSH, 16'h0000, 8'h00, 2, 1'b0);
        cpu_cycle(K_MRD,  16'h0001, 8'h00, 1, 1'b1);
        cpu_cycle(K_RFSH, 16'h0001, 8'h00, 2, 1'b0);
        cpu_cycle(K_MRD,  16'h6029, 8'h00, 0, 1'b0);
        cpu_cycle(K_MWR,  16'h6029, 8'hB7, 0, 1'b0);
        check("store_6029", store[16'h6029], 8'hB7);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        for (int i = 0; i < 65536; i++) model_mem[i] = init_byte(i);
        reset_n = 1'b0;
        A       = '0;
        dout    = '0;
        release_strobes();
        repeat (3) @(posedge clk);
        #1;
        check("rst_di",      di, 8'hFF);
        check("rst_wait_n",  32'(wait_n), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we",  32'(mem_we), 32'd0);
        check("rst_addr",    mem_addr, 16'h0000);
        check("rst_wdata",   mem_wdata, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        lat_fixed = 1;
        run_program();
        lat_fixed = 5;
        run_program();
        lat_fixed = 0;

        // OUT (0x42),A then IN A,(0x42) with A=5A
        cpu_cycle(K_IOWR, 16'h5A42, 8'h5A, 0, 1'b0);
        check("out_store", store[16'h1042], 8'h5A);
        cpu_cycle(K_IORD, 16'h5A42, 8'h00, 0, 1'b0);
        check("in_value", di, 8'h5A);
        cpu_cycle(K_INTA, 16'h0000, 8'h00, 2, 1'b0);
        check("inta_di", di, 8'hFF);

        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 5));
            cpu_cycle(kind, 16'($urandom), 8'($urandom),
                      int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Reset while a request is outstanding, then a stray late ack.
        responder_en = 1'b0;
        @(posedge clk); #1;
        A = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_req",  32'(mem_req), 32'd1);
        check("pre_rst_wait", 32'(wait_n), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        release_strobes();
        #1;
        check("mid_rst_wait", 32'(wait_n), 32'd1);
        check("mid_rst_di",   di, 8'hFF);
        check("mid_rst_addr", mem_addr, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        late_tok++;
        repeat (4) begin
            @(negedge clk);
            check("late_ack_req",  32'(mem_req), 32'd0);
            check("late_ack_wait", 32'(wait_n), 32'd1);
            check("late_ack_di",   di, 8'hFF);
        end
        check("late_ack_sent", late_seen, late_tok);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
